// File: rtl/dmem_arb_pkg.sv
// Shared types and default parameters for the two-core data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic grant_t;

    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_TIMEOUT_CYC = 16;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker: on a tie the core that did not win last time is chosen.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  grant_t     last_grant,
    output logic       valid,
    output grant_t     id
);

    always_comb begin
        valid = |req;
        id    = 1'b0;
        case (req)
            2'b01:   id = 1'b0;
            2'b10:   id = 1'b1;
            2'b11:   id = ~last_grant;
            default: id = 1'b0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-core data-memory arbiter: IDLE/BUSY/RESP FSM with round-robin grant on ties.
// Optional abort of stalled accesses is built in when DMEM_ARB_TIMEOUT_EN is defined.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c0_mem_read,
    input  logic              c0_mem_write,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [DATA_W-1:0] c0_wdata,
    output logic [DATA_W-1:0] c0_rdata,
    output logic              c0_ready,
    output logic              c0_err,
    input  logic              c1_mem_read,
    input  logic              c1_mem_write,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [DATA_W-1:0] c1_wdata,
    output logic [DATA_W-1:0] c1_rdata,
    output logic              c1_ready,
    output logic              c1_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [1:0]        fsm_state
);

    // Handshake: a core holds read/write as a level until its ready pulses for
    // one cycle; memory sees mem_req held with stable fields until the mem_ack cycle.

    state_t            state, next_state;
    grant_t            gid_q, last_grant, gnt_id;
    logic              gnt_valid;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              timeout_hit;
    logic              c0_req, c1_req;

    assign c0_req = c0_mem_read | c0_mem_write;
    assign c1_req = c1_mem_read | c1_mem_write;

    rr_arb2 u_arb (
        .req        ({c1_req, c0_req}),
        .last_grant (last_grant),
        .valid      (gnt_valid),
        .id         (gnt_id)
    );

`ifdef DMEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] busy_cnt;

    always_ff @(posedge clk) begin
        if (rst || state != BUSY) begin
            busy_cnt <= '0;
        end else begin
            busy_cnt <= busy_cnt + 1'b1;
        end
    end

    // A same-cycle mem_ack wins over the abort.
    assign timeout_hit = (state == BUSY) && !mem_ack &&
                         (busy_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state == IDLE) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_q       = 1'b0;
`endif

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (gnt_valid) next_state = BUSY;
            BUSY:    if (mem_ack || timeout_hit) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            gid_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && gnt_valid) begin
                gid_q   <= gnt_id;
                // Read and write both set counts as a write.
                we_q    <= gnt_id ? c1_mem_write : c0_mem_write;
                addr_q  <= gnt_id ? c1_addr : c0_addr;
                wdata_q <= gnt_id ? c1_wdata : c0_wdata;
                rdata_q <= '0;
            end
            if (state == BUSY && mem_ack) begin
                rdata_q <= we_q ? '0 : mem_rdata;
            end
            if (state == RESP) begin
                last_grant <= gid_q;
            end
        end
    end

    assign mem_req   = (state == BUSY);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign fsm_state = state;

    assign c0_ready = (state == RESP) && (gid_q == 1'b0);
    assign c1_ready = (state == RESP) && (gid_q == 1'b1);
    assign c0_rdata = c0_ready ? rdata_q : '0;
    assign c1_rdata = c1_ready ? rdata_q : '0;
    assign c0_err   = c0_ready & err_q;
    assign c1_err   = c1_ready & err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model of grant order and response data.
module tb_dmem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              c0_mem_read, c0_mem_write, c1_mem_read, c1_mem_write;
    logic [ADDR_W-1:0] c0_addr, c1_addr;
    logic [DATA_W-1:0] c0_wdata, c1_wdata;
    logic [DATA_W-1:0] c0_rdata, c1_rdata;
    logic              c0_ready, c1_ready, c0_err, c1_err;
    logic              mem_req, mem_we, mem_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic [1:0]        fsm_state;

    int vec;
    int errs;
    logic last_model;
    logic [DATA_W-1:0] exp_q[$];

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst),
        .c0_mem_read(c0_mem_read), .c0_mem_write(c0_mem_write),
        .c0_addr(c0_addr), .c0_wdata(c0_wdata), .c0_rdata(c0_rdata),
        .c0_ready(c0_ready), .c0_err(c0_err),
        .c1_mem_read(c1_mem_read), .c1_mem_write(c1_mem_write),
        .c1_addr(c1_addr), .c1_wdata(c1_wdata), .c1_rdata(c1_rdata),
        .c1_ready(c1_ready), .c1_err(c1_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .fsm_state(fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_all();
        c0_mem_read = 0; c0_mem_write = 0; c1_mem_read = 0; c1_mem_write = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; drop_all(); mem_ack = 0;
        step(); step();
        rst = 1'b0;
        last_model = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vec++; if (mem_req !== 1'b0) begin errs++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
        vec++; if (mem_we !== 1'b0) begin errs++; $display("FAIL reset_mem_we got %b exp 0", mem_we); end
        vec++; if (mem_addr !== '0) begin errs++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
        vec++; if (mem_wdata !== '0) begin errs++; $display("FAIL reset_mem_wdata got %h exp 0", mem_wdata); end
        vec++; if ({c0_ready, c1_ready, c0_err, c1_err} !== 4'b0) begin errs++;
            $display("FAIL reset_flags got %b exp 0000", {c0_ready, c1_ready, c0_err, c1_err}); end
        vec++; if ({c0_rdata, c1_rdata} !== '0) begin errs++; $display("FAIL reset_rdata got %h exp 0", {c0_rdata, c1_rdata}); end
    endtask

    task automatic test_single_read();
        c0_mem_read = 1; c0_addr = 32'h100;
        vec++; if (mem_req !== 1'b0) begin errs++; $display("FAIL rd_req_t0 got %b exp 0", mem_req); end
        step();
        vec++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin errs++;
            $display("FAIL rd_req_t1 got req=%b we=%b addr=%h exp 1 0 100", mem_req, mem_we, mem_addr); end
        mem_ack = 1; mem_rdata = 32'hDEADBEEF;
        step();
        mem_ack = 0;
        vec++; if (c0_ready !== 1'b1 || c0_rdata !== 32'hDEADBEEF || c0_err !== 1'b0) begin errs++;
            $display("FAIL rd_resp got rdy=%b data=%h err=%b exp 1 deadbeef 0", c0_ready, c0_rdata, c0_err); end
        vec++; if (c1_ready !== 1'b0 || c1_rdata !== '0) begin errs++;
            $display("FAIL rd_other got rdy=%b data=%h exp 0 0", c1_ready, c1_rdata); end
        c0_mem_read = 0; last_model = 1'b0;
        step();
        vec++; if (c0_ready !== 1'b0 || mem_req !== 1'b0) begin errs++;
            $display("FAIL rd_after got rdy=%b req=%b exp 0 0", c0_ready, mem_req); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        c0_mem_write = 1; c0_addr = 32'hA0; c0_wdata = 32'h1111;
        c1_mem_write = 1; c1_addr = 32'hA4; c1_wdata = 32'h2222;
        step();
        vec++; if (mem_req !== 1 || mem_we !== 1 || mem_addr !== 32'hA0 || mem_wdata !== 32'h1111) begin errs++;
            $display("FAIL b2b_first got req=%b we=%b addr=%h wd=%h exp 1 1 a0 1111", mem_req, mem_we, mem_addr, mem_wdata); end
        mem_ack = 1; mem_rdata = 32'hCAFE0000;
        step();
        mem_ack = 0;
        vec++; if (c0_ready !== 1 || c0_rdata !== '0 || c1_ready !== 0) begin errs++;
            $display("FAIL b2b_resp0 got r0=%b d0=%h r1=%b exp 1 0 0", c0_ready, c0_rdata, c1_ready); end
        c0_mem_write = 0;
        step();
        vec++; if (mem_req !== 0) begin errs++; $display("FAIL b2b_idle got req=%b exp 0", mem_req); end
        step();
        vec++; if (mem_req !== 1 || mem_addr !== 32'hA4 || mem_wdata !== 32'h2222 || mem_we !== 1) begin errs++;
            $display("FAIL b2b_second got req=%b addr=%h wd=%h exp 1 a4 2222", mem_req, mem_addr, mem_wdata); end
        mem_ack = 1;
        step();
        mem_ack = 0;
        vec++; if (c1_ready !== 1 || c0_ready !== 0 || c1_rdata !== '0) begin errs++;
            $display("FAIL b2b_resp1 got r1=%b r0=%b d1=%h exp 1 0 0", c1_ready, c0_ready, c1_rdata); end
        c1_mem_write = 0;
        step();
        c0_mem_write = 1; c1_mem_write = 1;
        step();
        vec++; if (mem_addr !== 32'hA0) begin errs++; $display("FAIL b2b_repeat got addr=%h exp a0", mem_addr); end
        mem_ack = 1;
        step();
        mem_ack = 0;
        vec++; if (c0_ready !== 1 || c1_ready !== 0) begin errs++;
            $display("FAIL b2b_repeat_resp got r0=%b r1=%b exp 1 0", c0_ready, c1_ready); end
        drop_all(); last_model = 1'b0;
        step();
    endtask

    task automatic test_delayed_write();
        c1_mem_write = 1; c1_addr = 32'h4; c1_wdata = 32'h55;
        step();
        for (int i = 0; i < 6; i++) begin
            vec++; if (mem_req !== 1 || mem_addr !== 32'h4 || mem_wdata !== 32'h55 || mem_we !== 1 || c1_ready !== 0) begin errs++;
                $display("FAIL dly_busy%0d got req=%b addr=%h wd=%h rdy=%b exp 1 4 55 0", i, mem_req, mem_addr, mem_wdata, c1_ready); end
            if (i == 1) begin c0_mem_read = 1; c0_addr = 32'h800; end
            if (i == 2) c1_mem_write = 0;
            mem_rdata = $urandom;
            if (i == 5) mem_ack = 1;
            step();
        end
        mem_ack = 0;
        vec++; if (c1_ready !== 1 || c1_rdata !== '0 || c0_ready !== 0) begin errs++;
            $display("FAIL dly_resp got r1=%b d1=%h r0=%b exp 1 0 0", c1_ready, c1_rdata, c0_ready); end
        drop_all(); last_model = 1'b1;
        step();
        vec++; if (c1_ready !== 0 || mem_req !== 0) begin errs++;
            $display("FAIL dly_once got r1=%b req=%b exp 0 0", c1_ready, mem_req); end
    endtask

    task automatic test_reset_mid();
        c1_mem_read = 1; c1_addr = 32'h200;
        step();
        vec++; if (mem_req !== 1) begin errs++; $display("FAIL rstmid_busy got req=%b exp 1", mem_req); end
        rst = 1;
        step();
        rst = 0; c1_mem_read = 0; mem_ack = 1;
        vec++; if (mem_req !== 0 || c1_ready !== 0 || mem_addr !== '0) begin errs++;
            $display("FAIL rstmid_after got req=%b rdy=%b addr=%h exp 0 0 0", mem_req, c1_ready, mem_addr); end
        step();
        mem_ack = 0;
        vec++; if (c0_ready !== 0 || c1_ready !== 0 || mem_req !== 0) begin errs++;
            $display("FAIL rstmid_stray_ack got r0=%b r1=%b req=%b exp 0 0 0", c0_ready, c1_ready, mem_req); end
        last_model = 1'b1;
    endtask

    task automatic test_timeout();
        c0_mem_write = 1; c0_addr = 32'h40; c0_wdata = 32'h77;
        step();
`ifdef DMEM_ARB_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            vec++; if (mem_req !== 1 || c0_ready !== 0) begin errs++;
                $display("FAIL to_wait%0d got req=%b rdy=%b exp 1 0", i, mem_req, c0_ready); end
            step();
        end
        vec++; if (c0_ready !== 1 || c0_err !== 1 || c0_rdata !== '0 || mem_req !== 0) begin errs++;
            $display("FAIL to_abort got rdy=%b err=%b data=%h req=%b exp 1 1 0 0", c0_ready, c0_err, c0_rdata, mem_req); end
`else
        for (int i = 0; i < 100; i++) begin
            vec++; if (mem_req !== 1 || c0_ready !== 0 || c0_err !== 0) begin errs++;
                $display("FAIL to_wait%0d got req=%b rdy=%b err=%b exp 1 0 0", i, mem_req, c0_ready, c0_err); end
            step();
        end
        mem_ack = 1;
        step();
        mem_ack = 0;
        vec++; if (c0_ready !== 1 || c0_err !== 0) begin errs++;
            $display("FAIL to_late_ack got rdy=%b err=%b exp 1 0", c0_ready, c0_err); end
`endif
        drop_all(); last_model = 1'b0;
        step();
    endtask

    task automatic test_random();
        logic [1:0]        r0, r1;
        logic              g, exp_we, other_rdy;
        logic [ADDR_W-1:0] a0, a1, exp_addr;
        logic [DATA_W-1:0] w0, w1, exp_wd, rd, got_rd, exp_rd, other_rd;
        int                d;
        for (int n = 0; n < 300; n++) begin
            r0 = 2'($urandom_range(0, 3)); r1 = 2'($urandom_range(0, 3));
            a0 = $urandom; a1 = $urandom; w0 = $urandom; w1 = $urandom;
            c0_mem_read = r0[0]; c0_mem_write = r0[1]; c0_addr = a0; c0_wdata = w0;
            c1_mem_read = r1[0]; c1_mem_write = r1[1]; c1_addr = a1; c1_wdata = w1;
            if (r0 == 0 && r1 == 0) begin
                mem_ack = 1'($urandom_range(0, 1));
                step();
                mem_ack = 0;
                vec++; if (mem_req !== 0 || c0_ready !== 0 || c1_ready !== 0) begin errs++;
                    $display("FAIL rnd_idle%0d got req=%b r0=%b r1=%b exp 0 0 0", n, mem_req, c0_ready, c1_ready); end
                continue;
            end
            g        = (r0 != 0 && r1 != 0) ? ~last_model : (r1 != 0);
            exp_we   = g ? r1[1] : r0[1];
            exp_addr = g ? a1 : a0;
            exp_wd   = g ? w1 : w0;
            step();
            d = $urandom_range(0, 4);
            for (int i = 0; i <= d; i++) begin
                vec++; if (mem_req !== 1 || mem_we !== exp_we || mem_addr !== exp_addr || mem_wdata !== exp_wd) begin errs++;
                    $display("FAIL rnd_busy%0d got req=%b we=%b addr=%h wd=%h exp 1 %b %h %h", n, mem_req, mem_we, mem_addr, mem_wdata, exp_we, exp_addr, exp_wd); end
                if ($urandom_range(0, 3) == 0) begin
                    if (g) begin c1_mem_read = 0; c1_mem_write = 0; end
                    else   begin c0_mem_read = 0; c0_mem_write = 0; end
                end
                rd = $urandom; mem_rdata = rd;
                if (i == d) begin
                    mem_ack = 1;
                    exp_q.push_back(exp_we ? '0 : rd);
                end
                step();
            end
            mem_ack = 0;
            exp_rd    = exp_q.pop_front();
            got_rd    = g ? c1_rdata : c0_rdata;
            other_rd  = g ? c0_rdata : c1_rdata;
            other_rdy = g ? (c0_ready | c0_err) : (c1_ready | c1_err);
            vec++; if ((g ? c1_ready : c0_ready) !== 1 || (g ? c1_err : c0_err) !== 0 || got_rd !== exp_rd) begin errs++;
                $display("FAIL rnd_resp%0d core%0d got r0=%b r1=%b data=%h exp data %h", n, g, c0_ready, c1_ready, got_rd, exp_rd); end
            vec++; if (other_rdy !== 0 || other_rd !== '0) begin errs++;
                $display("FAIL rnd_other%0d got rdy/err=%b data=%h exp 0 0", n, other_rdy, other_rd); end
            last_model = g;
            drop_all();
            step();
            vec++; if (c0_ready !== 0 || c1_ready !== 0 || mem_req !== 0) begin errs++;
                $display("FAIL rnd_post%0d got r0=%b r1=%b req=%b exp 0 0 0", n, c0_ready, c1_ready, mem_req); end
        end
    endtask

    initial begin
        vec = 0; errs = 0;
        rst = 1; mem_ack = 0; mem_rdata = '0;
        c0_addr = '0; c0_wdata = '0; c1_addr = '0; c1_wdata = '0;
        drop_all();
        last_model = 1'b1;
        test_reset();
        test_single_read();
        test_back_to_back();
        test_delayed_write();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
